// File: rtl/alu_req_arbiter_pkg.sv
// Definitions shared by the ALU request arbiter: the 4-bit ALU opcode map,
// the last legal opcode and the arbiter FSM state type.
package alu_req_arbiter_pkg;

  typedef logic [3:0] alu_op_t;

  // Opcode map understood by the shared lab ALU
  localparam alu_op_t doNothing = 4'h0;
  localparam alu_op_t addu      = 4'h1;
  localparam alu_op_t subu      = 4'h2;
  localparam alu_op_t andOp     = 4'h3;
  localparam alu_op_t orOp      = 4'h4;
  localparam alu_op_t xorOp     = 4'h5;
  localparam alu_op_t notA      = 4'h6;
  localparam alu_op_t shiftL    = 4'h7;
  localparam alu_op_t shiftR    = 4'h8;
  localparam alu_op_t incA      = 4'h9;
  localparam alu_op_t decA      = 4'hA;
  localparam alu_op_t passA     = 4'hB;
  localparam alu_op_t passB     = 4'hC;
  localparam alu_op_t adduTwo   = 4'hD;

  // Anything above this opcode (4'hE, 4'hF) is rejected without touching the ALU
  localparam alu_op_t OP_LAST = adduTwo;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_t;

  function automatic logic isLegalOp(input alu_op_t op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Combinational round-robin picker for the ALU request arbiter.
// Returns the first valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
// Optional feature macro: ALU_ARB_PRIO_EN -- requester 0 wins whenever it is
// valid and the rotation only covers requesters 1..NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rrPtr,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       anyValid
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] eligible;
  int                 idx;

  // Scan from the farthest offset back to rrPtr so the nearest valid request wins
  always_comb begin
    grant    = '0;
    anyValid = 1'b0;
    idx      = 0;
    eligible = req;
`ifdef ALU_ARB_PRIO_EN
    eligible[0] = 1'b0;
`endif
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rrPtr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[IW'(idx)]) begin
        grant    = IW'(idx);
        anyValid = 1'b1;
      end
    end
`ifdef ALU_ARB_PRIO_EN
    if (req[0]) begin
      grant    = '0;
      anyValid = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NUM_REQ requesters. A round-robin grant is taken in
// IDLE, the latched opcode/operands are held on the ALU for ALU_LAT cycles,
// and the captured result is returned with the requester index. Illegal
// opcodes skip the ALU and produce an error response one cycle later.
// Optional feature macro: ALU_ARB_PRIO_EN (requester 0 has strict priority
// and does not move the round-robin pointer).
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][3:0]       req_op,
  input  logic [NUM_REQ-1:0][W-1:0]     req_a,
  input  logic [NUM_REQ-1:0][W-1:0]     req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [3:0]                    alu_op,
  output logic [W-1:0]                  alu_a,
  output logic [W-1:0]                  alu_b,
  input  logic [W-1:0]                  alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [W-1:0]                  rsp_data,
  output logic                          rsp_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);

  arb_state_t    state;
  logic [IW-1:0] rrPtr;
  logic [IW-1:0] grant;
  logic [IW-1:0] nextPtr;
  logic [IW-1:0] latId;
  logic [LW-1:0] latCnt;
  logic          anyValid;
  alu_op_t       grantOp;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) uPick (
    .req      (req_valid),
    .rrPtr    (rrPtr),
    .grant    (grant),
    .anyValid (anyValid)
  );

  // Pointer for the next rotation and the opcode offered by the current winner
  always_comb begin
    nextPtr = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
    grantOp = req_op[grant];
  end

  // Accept strobe goes to the winner in IDLE only, and is forced low while in reset
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == ARB_IDLE) && anyValid) req_ready[grant] = 1'b1;
  end

  // Arbiter FSM: grant and latch in IDLE, hold the ALU in EXEC, hold the response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      rrPtr     <= '0;
      latId     <= '0;
      latCnt    <= '0;
      alu_op    <= doNothing;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (anyValid) begin
            latId <= grant;
`ifdef ALU_ARB_PRIO_EN
            if (grant != '0) rrPtr <= nextPtr;
`else
            rrPtr <= nextPtr;
`endif
            if (isLegalOp(grantOp)) begin
              alu_op <= grantOp;
              alu_a  <= req_a[grant];
              alu_b  <= req_b[grant];
              latCnt <= '0;
              state  <= ARB_EXEC;
            end else begin
              rsp_valid <= 1'b1;
              rsp_id    <= grant;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              state     <= ARB_RESP;
            end
          end
        end

        ARB_EXEC: begin
          if (latCnt == LAT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_id    <= latId;
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            alu_op    <= doNothing;
            alu_a     <= '0;
            alu_b     <= '0;
            latCnt    <= '0;
            state     <= ARB_RESP;
          end else begin
            latCnt <= latCnt + LW'(1);
          end
        end

        ARB_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state     <= ARB_IDLE;
          end
        end

        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
